time_counter: RTL and testbench
===============================

# time_counter

Time-of-day keeper for the alarm clock: maintains the running BCD HH:MM:SS value and applies the hour/minute edit pulses that the mode block routes to the clock path. Its `current_time` output feeds the mode block's display mux and alarm comparator, while its edit inputs consume that block's `clock_edit_btns` pulses. It sits between the top-level clock/reset and the mode/display logic.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per second. Legal range is ≥ 2.
- `clk` input, 1 bit: system clock. The single clock domain.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `edit_btns` input, 2 bits: single-cycle edit pulses, already edge-detected upstream.
  - [1] increments hours.
  - [0] increments minutes.
- `current_time` output, 20 bits: registered BCD time.
  - [19:18] hour tens, 0–2.
  - [17:14] hour units.
  - [13:11] minute tens, 0–5.
  - [10:7] minute units.
  - [6:4] second tens, 0–5.
  - [3:0] second units.
- `sec_tick` output, 1 bit: registered one-cycle pulse, asserted in the cycle after each 1 s prescaler wrap.

## Operation
- **Prescaler.** Counter `div_cnt` counts 0..TICK_DIV-1 and then wraps to 0. Internal `tick` is true when `div_cnt == TICK_DIV-1`.
- **Second rollover on `tick`.**
  - Second units 9→0 carries into second tens.
  - Second tens 5→0 carries into minutes.
- **Minute rollover on `tick`.**
  - Minutes 59→00 carries into hours.
  - Hours 23→00 has no further carry.
  - Units/tens rollover follows the same BCD rules as seconds.
- **Hour edit (`edit_btns[1]`).**
  - Hours := (hours + 1) mod 24 in BCD: 09→10, 19→20, 23→00.
  - No effect on minutes or seconds.
- **Minute edit (`edit_btns[0]`).**
  - Minutes := (minutes + 1) mod 60 in BCD: 59→00.
  - Never carries into hours.
- **Both edit bits in the same cycle.** Hours and minutes each increment independently.
- **Edit and `tick` in the same cycle.**
  - Edits take precedence over tick carries.
  - Seconds still advance.
  - Any seconds→minutes carry from that tick is discarded: 59→00 with no minute increment.
  - The edit result is the only change to hours and minutes.
- **Invalid BCD.** Never produced. Every field stays within its legal range at all times.
- **Reset (asserted at any time, including mid-second).**
  - `div_cnt` := 0.
  - `current_time` := 20'h0 (00:00:00).
  - `sec_tick` := 0.
  - After deassertion, the first `tick` occurs TICK_DIV cycles later.

## Timing
- **Edit latency.** The `edit_btns` pulse is sampled at edge N. `current_time` shows the new value after edge N; it is visible to downstream logic in cycle N+1.
- **Tick latency.**
  - `div_cnt == TICK_DIV-1` at edge N updates the seconds at edge N.
  - `sec_tick` is high for exactly the cycle after edge N, aligned with the new seconds value.
- **Tick period.** Exactly TICK_DIV cycles between consecutive `sec_tick` pulses. Edits do not disturb the prescaler (but see the Configuration macro).
- **Held edit input.** An input held high for k cycles produces k increments. Upstream guarantees one-cycle pulses.
- **Output path.** All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Configuration
- **`TIME_COUNTER_SEC_CLEAR_EN` defined:**
  - A minute edit (`edit_btns[0]`) also clears the seconds to 00 and reloads `div_cnt` to 0 in the same edge.
  - Any coincident tick is discarded, and `sec_tick` is not asserted for it.
  - The next tick occurs TICK_DIV cycles after the edit.
  - Hour edits are unaffected.
- **Not defined:** seconds and the prescaler run freely through edits, exactly as described in Operation.

## Test plan
- **Reset and free-run.** TICK_DIV=4. Release reset and run 240 cycles → `current_time` = 00:01:00 (20'h00080); `sec_tick` pulses exactly every 4 cycles.
- **Full-day rollover.** Preload via edits to 23:59, then let 60 ticks run → 00:00:00; hours do not exceed 23 at any point.
- **Edit wrap.** Apply 24 hour pulses from 00 → back to 00, passing through 09→10 and 19→20. Apply 60 minute pulses from 00 → 00 with hours unchanged.
- **Simultaneous events.**
  - Time 10:20:59: minute pulse coincident with a tick → 10:21:00, with no extra minute.
  - Hour and minute pulses in the same cycle at 05:59 → 06:00.
- **Mid-second reset.** Assert reset at `div_cnt`=2 while at 12:34:56 → 00:00:00 immediately; the first tick arrives 4 cycles after deassertion.
- **`TIME_COUNTER_SEC_CLEAR_EN`.**
  - Minute pulse at 08:15:37 with `div_cnt`=2 → 08:16:00; the next `sec_tick` follows 4 cycles later.
  - Without the macro, the same stimulus → 08:16:37, and the tick timing is unchanged.

Source files
------------

// File: rtl/time_counter.sv
// time_counter
// -----------------------------------------------------------------------------
// Time-of-day keeper for the alarm clock. Divides the system clock down to a
// one-second tick, advances a BCD HH:MM:SS value on every tick, and applies
// the hour/minute edit pulses routed from the mode block.
//
// Parameters:
//   TICK_DIV      clk cycles per second (must be >= 2)
//
// Ports:
//   clk           system clock, single domain
//   reset         asynchronous, active-high reset
//   edit_btns     [1] hour increment pulse, [0] minute increment pulse
//   current_time  registered BCD time {hT[1:0], hU[3:0], mT[2:0], mU[3:0],
//                 sT[2:0], sU[3:0]}
//   sec_tick      registered one-cycle pulse after each one-second wrap
//
// Optional feature macro: TIME_COUNTER_SEC_CLEAR_EN
//   When defined, a minute edit also zeroes the seconds and restarts the
//   prescaler, swallowing any tick that lands on the same edge.
// -----------------------------------------------------------------------------
module time_counter #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  edit_btns,
  output logic [19:0] current_time,
  output logic        sec_tick
);

  localparam int DivW = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] divCnt_q, divCnt_d;
  logic            secTick_q, secTick_d;
  logic [3:0]      secU_q, secU_d;
  logic [2:0]      secT_q, secT_d;
  logic [3:0]      minU_q, minU_d;
  logic [2:0]      minT_q, minT_d;
  logic [3:0]      hrU_q, hrU_d;
  logic [1:0]      hrT_q, hrT_d;

  logic tick;
  logic secClear;
  logic secCarry;
  logic anyEdit;
  logic minInc;
  logic minCarry;
  logic hrInc;

  // Next-state logic. Any edit in a cycle suppresses the seconds->minutes
  // carry entirely, so the edit result is the only change to hours/minutes
  // while the seconds themselves still advance on the tick.
  always_comb begin
    tick     = (divCnt_q == DivMax);
`ifdef TIME_COUNTER_SEC_CLEAR_EN
    secClear = edit_btns[0];
`else
    secClear = 1'b0;
`endif
    anyEdit  = |edit_btns;

    divCnt_d  = tick ? '0 : divCnt_q + DivW'(1);
    secTick_d = tick;
    if (secClear) begin
      divCnt_d  = '0;
      secTick_d = 1'b0;
    end

    secU_d   = secU_q;
    secT_d   = secT_q;
    secCarry = 1'b0;
    if (secClear) begin
      secU_d = 4'd0;
      secT_d = 3'd0;
    end else if (tick) begin
      if (secU_q == 4'd9) begin
        secU_d = 4'd0;
        if (secT_q == 3'd5) begin
          secT_d   = 3'd0;
          secCarry = 1'b1;
        end else begin
          secT_d = secT_q + 3'd1;
        end
      end else begin
        secU_d = secU_q + 4'd1;
      end
    end

    minInc   = edit_btns[0] | (secCarry & ~anyEdit);
    minCarry = secCarry & ~anyEdit & (minT_q == 3'd5) & (minU_q == 4'd9);
    hrInc    = edit_btns[1] | minCarry;

    minU_d = minU_q;
    minT_d = minT_q;
    if (minInc) begin
      if (minU_q == 4'd9) begin
        minU_d = 4'd0;
        minT_d = (minT_q == 3'd5) ? 3'd0 : minT_q + 3'd1;
      end else begin
        minU_d = minU_q + 4'd1;
      end
    end

    hrU_d = hrU_q;
    hrT_d = hrT_q;
    if (hrInc) begin
      if (hrT_q == 2'd2 && hrU_q == 4'd3) begin
        hrU_d = 4'd0;
        hrT_d = 2'd0;
      end else if (hrU_q == 4'd9) begin
        hrU_d = 4'd0;
        hrT_d = hrT_q + 2'd1;
      end else begin
        hrU_d = hrU_q + 4'd1;
      end
    end
  end

  // State registers; reset drops everything back to 00:00:00 mid-second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt_q  <= '0;
      secTick_q <= 1'b0;
      secU_q    <= 4'd0;
      secT_q    <= 3'd0;
      minU_q    <= 4'd0;
      minT_q    <= 3'd0;
      hrU_q     <= 4'd0;
      hrT_q     <= 2'd0;
    end else begin
      divCnt_q  <= divCnt_d;
      secTick_q <= secTick_d;
      secU_q    <= secU_d;
      secT_q    <= secT_d;
      minU_q    <= minU_d;
      minT_q    <= minT_d;
      hrU_q     <= hrU_d;
      hrT_q     <= hrT_d;
    end
  end

  assign current_time = {hrT_q, hrU_q, minT_q, minU_q, secT_q, secU_q};
  assign sec_tick     = secTick_q;

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter
// -----------------------------------------------------------------------------
// Directed bench for time_counter with TICK_DIV = 4. Expected values are
// worked out by hand from the edge count since the last reset release: after
// k edges with no seconds-clearing edits the seconds equal k/4 and the
// prescaler equals k%4. Where the seconds-clear option changes the timing the
// expected constants switch with the same macro.
// -----------------------------------------------------------------------------
module tb_time_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  edit_btns;
  logic [19:0] current_time;
  logic        sec_tick;

  int total;
  int bad;

`ifdef TIME_COUNTER_SEC_CLEAR_EN
  localparam logic [19:0] DayPre   = 20'h8EC80;
  localparam int          DayTo59  = 236;
  localparam int          SimWait  = 239;
  localparam logic        SimTick  = 1'b0;
  localparam int          MidWait  = 226;
  localparam int          ClrWait  = 150;
  localparam logic [19:0] ClrExp   = 20'h20B00;
  localparam int          ClrGap   = 4;
`else
  localparam logic [19:0] DayPre   = 20'h8EC94;
  localparam int          DayTo59  = 177;
  localparam int          SimWait  = 219;
  localparam logic        SimTick  = 1'b1;
  localparam int          MidWait  = 192;
  localparam int          ClrWait  = 135;
  localparam logic [19:0] ClrExp   = 20'h20B37;
  localparam int          ClrGap   = 1;
`endif

  time_counter #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .edit_btns    (edit_btns),
    .current_time (current_time),
    .sec_tick     (sec_tick)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so a stuck run still reports.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the given edit pattern for n edges, then releases it.
  task automatic applyStimulus(input logic [1:0] edits, input int n);
    edit_btns = edits;
    runCycles(n);
    edit_btns = 2'b00;
  endtask

  // Called just after an edge; edge count restarts at release.
  task automatic resetDut();
    reset = 1'b1;
    runCycles(1);
    reset = 1'b0;
  endtask

  function automatic bit hourBad(input logic [19:0] t);
    return (t[19:18] > 2'd2) || (t[17:14] > 4'd9) ||
           (t[19:18] == 2'd2 && t[17:14] > 4'd3);
  endfunction

  initial begin
    int pulses;
    int misplaced;
    int rangeErr;
    int gap;
    bit found;

    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    edit_btns = 2'b00;

    // Reset state and free run
    runCycles(1);
    checkOutput("resetTime", 32'(current_time), 32'h0);
    checkOutput("resetTick", 32'(sec_tick), 32'h0);
    reset     = 1'b0;
    pulses    = 0;
    misplaced = 0;
    for (int k = 1; k <= 240; k++) begin
      runCycles(1);
      if (k <= 8) checkOutput("earlyTick", 32'(sec_tick), 32'((k % 4) == 0));
      if (sec_tick) pulses++;
      if (sec_tick != ((k % 4) == 0)) misplaced++;
    end
    checkOutput("freeRunTime", 32'(current_time), 32'h00080);
    checkOutput("tickCount", 32'(pulses), 32'd60);
    checkOutput("tickMisplaced", 32'(misplaced), 32'd0);

    // Full-day rollover from 23:59
    resetDut();
    applyStimulus(2'b11, 23);
    applyStimulus(2'b01, 36);
    checkOutput("preload2359", 32'(current_time), 32'(DayPre));
    rangeErr = 0;
    for (int k = 0; k < DayTo59; k++) begin
      runCycles(1);
      if (hourBad(current_time)) rangeErr++;
    end
    checkOutput("day235959", 32'(current_time), 32'h8ECD9);
    for (int k = 0; k < 4; k++) begin
      runCycles(1);
      if (hourBad(current_time)) rangeErr++;
    end
    checkOutput("dayWrap", 32'(current_time), 32'h0);
    checkOutput("hourRange", 32'(rangeErr), 32'd0);

    // Hour and minute edit wrap
    resetDut();
    for (int h = 1; h <= 24; h++) begin
      applyStimulus(2'b10, 1);
      if (h == 9)  checkOutput("hr09", 32'(current_time[19:14]), 32'h09);
      if (h == 10) checkOutput("hr10", 32'(current_time[19:14]), 32'h10);
      if (h == 19) checkOutput("hr19", 32'(current_time[19:14]), 32'h19);
      if (h == 20) checkOutput("hr20", 32'(current_time[19:14]), 32'h20);
      if (h == 23) checkOutput("hr23", 32'(current_time[19:14]), 32'h23);
    end
    checkOutput("hrWrap", 32'(current_time[19:14]), 32'h00);
    checkOutput("hrWrapMin", 32'(current_time[13:7]), 32'h00);
    for (int m = 1; m <= 60; m++) begin
      applyStimulus(2'b01, 1);
      if (m == 9)  checkOutput("min09", 32'(current_time[13:7]), 32'h09);
      if (m == 10) checkOutput("min10", 32'(current_time[13:7]), 32'h10);
      if (m == 59) checkOutput("min59", 32'(current_time[13:7]), 32'h59);
    end
    checkOutput("minWrap", 32'(current_time[13:7]), 32'h00);
    checkOutput("minWrapHr", 32'(current_time[19:14]), 32'h00);

    // Minute pulse coincident with a carrying tick at 10:20:59
    resetDut();
    applyStimulus(2'b11, 10);
    applyStimulus(2'b01, 10);
    runCycles(SimWait);
    checkOutput("pre102059", 32'(current_time), 32'h41059);
    applyStimulus(2'b01, 1);
    checkOutput("edit102100", 32'(current_time), 32'h41080);
    checkOutput("editTickPulse", 32'(sec_tick), 32'(SimTick));

    // Both edits together at 05:59
    resetDut();
    applyStimulus(2'b11, 5);
    applyStimulus(2'b01, 54);
    checkOutput("pre0559", 32'(current_time[19:7]), 32'({6'h05, 7'h59}));
    applyStimulus(2'b11, 1);
    checkOutput("both0600", 32'(current_time[19:7]), 32'({6'h06, 7'h00}));

    // Mid-second reset at 12:34:56 with prescaler at 2
    resetDut();
    applyStimulus(2'b11, 12);
    applyStimulus(2'b01, 22);
    runCycles(MidWait);
    checkOutput("pre123456", 32'(current_time), 32'h49A56);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetTime", 32'(current_time), 32'h0);
    checkOutput("asyncResetTick", 32'(sec_tick), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      runCycles(1);
      checkOutput("postResetTick", 32'(sec_tick), 32'(k == 4));
    end
    checkOutput("postResetTime", 32'(current_time), 32'h00001);

    // Minute edit at 08:15:37 with prescaler at 2
    resetDut();
    applyStimulus(2'b11, 8);
    applyStimulus(2'b01, 7);
    runCycles(ClrWait);
    checkOutput("pre081537", 32'(current_time), 32'h20AB7);
    applyStimulus(2'b01, 1);
    checkOutput("clrEditTime", 32'(current_time), 32'(ClrExp));
    checkOutput("clrEditTick", 32'(sec_tick), 32'h0);
    gap   = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      runCycles(1);
      gap++;
      if (sec_tick) found = 1'b1;
    end
    checkOutput("clrTickGap", 32'(gap), 32'(ClrGap));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
